led_frame_scheduler: RTL and testbench
======================================

Name: led_frame_scheduler

Overview:
- Sits between two pixel-word sources and the parallel string driver's FIFO port.
- Source 0 is the host pixel FIFO; source 1 is a local fallback or test-pattern FIFO.
- Paces frame starts to a fixed period and enforces an LED latch gap after the strings go idle.
- Selects one source per frame and never switches sources mid-frame. It does this by gating the word count the driver sees, so the driver only starts when the scheduler allows it.

Parameters:
- FIFO_ADDR_WIDTH, 12: source and driver count width is FIFO_ADDR_WIDTH+1.
- FIFO_DATA_WIDTH, 16: pixel word width.
- FRAME_WORDS, 900: words per frame (N_STRINGS*N_LEDS*3/2).
- FRAME_PERIOD, 666667: clocks between frame-start opportunities (30 fps at 50 ns).
- LATCH_TICKS, 6000: clocks string_active must stay low before a new frame (300 us).
- FALLBACK_EN_P, 1: if 0, source 1 is never selected.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- enable  in  1  scheduler enable; sampled at frame boundaries only.
- src0_count  in  FIFO_ADDR_WIDTH+1  source 0 fill level.
- src0_data  in  FIFO_DATA_WIDTH  source 0 read data.
- src0_valid  in  1  source 0 read data valid.
- src0_read  out  1  source 0 pop strobe.
- src1_count, src1_data, src1_valid, src1_read: same as source 0, for source 1.
- drv_count  out  FIFO_ADDR_WIDTH+1  gated count presented to the driver.
- drv_data  out  FIFO_DATA_WIDTH  muxed data to the driver.
- drv_valid  out  1  muxed valid to the driver.
- drv_read  in  1  pop strobe from the driver.
- string_active  in  1  driver busy.
- frame_src  out  1  source of the current or last frame.
- frame_busy  out  1  high from frame grant until the latch gap has elapsed.
- underrun  out  1  one-clock pulse when a period tick finds no eligible source.

Behaviour:
- Reset (async, active-high): all outputs 0, state IDLE, period counter 0, word counter 0, latch counter 0.
- Period counter:
  - Free-runs 0..FRAME_PERIOD-1.
  - Generates a "tick" when it wraps.
  - A tick that is not consumed is latched as "pending" until consumed. Pending holds at most one tick; extra ticks are not counted.
- Eligibility: source k is eligible when src_k_count >= FRAME_WORDS.
- Source selection priority: source 0 first, then source 1 (only if FALLBACK_EN_P).
- States:
  - IDLE: drv_count=0. Move to ARB when pending && enable && latch_ok.
  - ARB, one clock:
    - If source 0 is eligible, select 0; else if source 1 is eligible, select 1.
    - If a source is selected: frame_src <= sel, clear pending, word counter <= 0, go to STREAM.
    - If none is eligible: pulse underrun, clear pending, go to IDLE.
  - STREAM:
    - drv_count = src_sel_count.
    - drv_read is routed to src_sel_read only; the other source's read stays 0.
    - drv_data/drv_valid come from the selected source; the other source's valid is ignored.
    - Each drv_read increments the word counter.
    - When the counter reaches FRAME_WORDS, drv_count is forced to 0 on the next clock and the state goes to DRAIN.
    - drv_read beyond FRAME_WORDS is still forwarded to the selected source (driver flush) but is not counted.
  - DRAIN: drv_count=0. Once string_active is seen high then low, clear the latch counter and go to LATCH.
  - LATCH:
    - Count clocks while string_active is low; restart from 0 if string_active goes high.
    - At LATCH_TICKS, latch_ok=1 and go to IDLE.
- latch_ok is 1 out of reset.
- frame_busy is high in ARB (when a grant is made), STREAM, DRAIN and LATCH.
- drv_data/drv_valid mux select is frame_src, held through DRAIN so that late read data is delivered.
- Simultaneous tick and ARB: the tick sets pending after the clear (it is not lost).
- enable low: the in-flight frame completes normally; no new ARB is entered.
- Count arithmetic: unsigned, FIFO_ADDR_WIDTH+1 bits. The word counter is $clog2(FRAME_WORDS+1) bits and saturates at FRAME_WORDS.

Optional Feature:
- LED_FRAME_STATS_EN: adds 32-bit output frames_src0, frames_src1 and underruns counters.
  - Counters increment on grant and on the underrun pulse, wrap at 2^32, and clear on reset.
- Without the macro: the ports and counters are absent and there is no other behavioural change.

Decomposition:
- Shared package led_pkg holds:
  - state typedef sched_state_t (IDLE, ARB, STREAM, DRAIN, LATCH);
  - SRC_HOST=0 and SRC_FALLBACK=1;
  - default timing constants CLK_PERIOD_NS=50, LATCH_US=300.
- One natural sub-module, frame_pacer: the period counter and pending latch, with a tick-consume handshake.

Test Plan:
All scenarios use FRAME_WORDS=8, FRAME_PERIOD=100, LATCH_TICKS=10.
- src0_count=8, tick: ARB selects 0, drv_count=8, after 8 drv_reads drv_count=0 and src1_read never asserts.
- src0_count=3, src1_count=8, FALLBACK_EN_P=1, tick: frame_src=1. Same stimulus with FALLBACK_EN_P=0: underrun pulses once and the state returns to IDLE.
- string_active drops after the frame, re-asserts at latch count 5, then drops: the next frame is not granted until 10 consecutive low clocks, even though a tick is pending.
- Async reset asserted mid-STREAM at word 4: all outputs 0 immediately; after release, IDLE waits for the next tick.
- Source 0 still has 8 words when the frame ends: no second frame until the next tick, giving exactly one frame per period.
- With LED_FRAME_STATS_EN: 3 granted frames and 1 underrun give frames_src0=3, underruns=1.

Source files
------------

// File: rtl/led_pkg.sv
// Shared scheduler state type, source identifiers and default timing constants.
package led_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARB,
        STREAM,
        DRAIN,
        LATCH
    } sched_state_t;

    localparam logic SRC_HOST     = 1'b0;
    localparam logic SRC_FALLBACK = 1'b1;

    localparam int CLK_PERIOD_NS = 50;
    localparam int LATCH_US      = 300;

endpackage

// File: rtl/led_frame_scheduler_frame_pacer.sv
// Free-running frame period counter with a single-entry pending latch and a consume handshake.
module frame_pacer
    import led_pkg::*;
#(
    parameter int FRAME_PERIOD = 666667
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_consume,
    output logic o_pending
);

    localparam int PC_W = (FRAME_PERIOD > 1) ? $clog2(FRAME_PERIOD) : 1;

    logic [PC_W-1:0] r_period_cnt;
    logic            r_pending;
    logic            w_tick;

    assign w_tick = (r_period_cnt == PC_W'(FRAME_PERIOD - 1));

    // A tick landing on the same clock as a consume re-arms pending.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_period_cnt <= '0;
            r_pending    <= 1'b0;
        end else begin
            r_period_cnt <= w_tick ? '0 : r_period_cnt + 1'b1;
            if (w_tick) begin
                r_pending <= 1'b1;
            end else if (i_consume) begin
                r_pending <= 1'b0;
            end
        end
    end

    assign o_pending = r_pending;

endmodule

// File: rtl/led_frame_scheduler.sv
// Paces frame starts, enforces the LED latch gap and grants one pixel source per frame.
// Define LED_FRAME_STATS_EN to add grant/underrun counters.
module led_frame_scheduler
    import led_pkg::*;
#(
    parameter int FIFO_ADDR_WIDTH = 12,
    parameter int FIFO_DATA_WIDTH = 16,
    parameter int FRAME_WORDS     = 900,
    parameter int FRAME_PERIOD    = 666667,
    parameter int LATCH_TICKS     = LATCH_US * 1000 / CLK_PERIOD_NS,
    parameter int FALLBACK_EN_P   = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic [FIFO_ADDR_WIDTH:0]   src0_count,
    input  logic [FIFO_DATA_WIDTH-1:0] src0_data,
    input  logic                       src0_valid,
    output logic                       src0_read,
    input  logic [FIFO_ADDR_WIDTH:0]   src1_count,
    input  logic [FIFO_DATA_WIDTH-1:0] src1_data,
    input  logic                       src1_valid,
    output logic                       src1_read,
    output logic [FIFO_ADDR_WIDTH:0]   drv_count,
    output logic [FIFO_DATA_WIDTH-1:0] drv_data,
    output logic                       drv_valid,
    input  logic                       drv_read,
    input  logic                       string_active,
    output logic                       frame_src,
    output logic                       frame_busy,
    output logic                       underrun
`ifdef LED_FRAME_STATS_EN
    ,
    output logic [31:0]                frames_src0,
    output logic [31:0]                frames_src1,
    output logic [31:0]                underruns
`endif
);

    localparam int CNT_W = FIFO_ADDR_WIDTH + 1;
    localparam int WC_W  = $clog2(FRAME_WORDS + 1);
    localparam int LC_W  = $clog2(LATCH_TICKS + 1);

    sched_state_t    r_state;
    sched_state_t    w_next_state;
    logic            r_frame_src;
    logic            r_latch_ok;
    logic            r_seen_active;
    logic [WC_W-1:0] r_word_cnt;
    logic [LC_W-1:0] r_latch_cnt;

    logic w_pending;
    logic w_consume;
    logic w_grant;
    logic w_sel;
    logic w_underrun;
    logic w_elig0;
    logic w_elig1;
    logic w_fwd;
    logic w_last_word;
    logic w_gap_done;

    frame_pacer #(
        .FRAME_PERIOD(FRAME_PERIOD)
    ) u_pacer (
        .i_clk    (clk),
        .i_reset  (reset),
        .i_consume(w_consume),
        .o_pending(w_pending)
    );

    assign w_elig0     = (src0_count >= CNT_W'(FRAME_WORDS));
    assign w_elig1     = (FALLBACK_EN_P != 0) && (src1_count >= CNT_W'(FRAME_WORDS));
    assign w_last_word = drv_read && (r_word_cnt == WC_W'(FRAME_WORDS - 1));
    assign w_gap_done  = !string_active && (r_latch_cnt == LC_W'(LATCH_TICKS - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_grant      = 1'b0;
        w_sel        = SRC_HOST;
        w_underrun   = 1'b0;
        w_consume    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_pending && enable && r_latch_ok) begin
                    w_next_state = ARB;
                end
            end
            ARB: begin
                w_consume = 1'b1;
                if (w_elig0) begin
                    w_grant      = 1'b1;
                    w_sel        = SRC_HOST;
                    w_next_state = STREAM;
                end else if (w_elig1) begin
                    w_grant      = 1'b1;
                    w_sel        = SRC_FALLBACK;
                    w_next_state = STREAM;
                end else begin
                    w_underrun   = 1'b1;
                    w_next_state = IDLE;
                end
            end
            STREAM: begin
                if (w_last_word) begin
                    w_next_state = DRAIN;
                end
            end
            // Strings must have been seen busy before their falling edge starts the gap.
            DRAIN: begin
                if (r_seen_active && !string_active) begin
                    w_next_state = LATCH;
                end
            end
            LATCH: begin
                if (w_gap_done) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_frame_src   <= SRC_HOST;
            r_word_cnt    <= '0;
            r_latch_cnt   <= '0;
            r_latch_ok    <= 1'b1;
            r_seen_active <= 1'b0;
        end else begin
            if (w_grant) begin
                r_frame_src   <= w_sel;
                r_word_cnt    <= '0;
                r_latch_ok    <= 1'b0;
                r_seen_active <= 1'b0;
            end else begin
                if (r_state == STREAM && drv_read && r_word_cnt != WC_W'(FRAME_WORDS)) begin
                    r_word_cnt <= r_word_cnt + 1'b1;
                end
                if (r_state == DRAIN && string_active) begin
                    r_seen_active <= 1'b1;
                end
                if (r_state == LATCH && w_gap_done) begin
                    r_latch_ok <= 1'b1;
                end
            end
            // Any busy clock during the gap restarts the count.
            if (r_state == LATCH) begin
                r_latch_cnt <= string_active ? '0 : r_latch_cnt + 1'b1;
            end else begin
                r_latch_cnt <= '0;
            end
        end
    end

    assign w_fwd      = (r_state == STREAM) || (r_state == DRAIN);
    assign drv_count  = (r_state == STREAM) ? (r_frame_src ? src1_count : src0_count) : '0;
    assign src0_read  = w_fwd && drv_read && (r_frame_src == SRC_HOST);
    assign src1_read  = w_fwd && drv_read && (r_frame_src == SRC_FALLBACK);
    assign drv_valid  = w_fwd && (r_frame_src ? src1_valid : src0_valid);
    assign drv_data   = w_fwd ? (r_frame_src ? src1_data : src0_data) : '0;
    assign frame_src  = r_frame_src;
    assign frame_busy = w_grant || (r_state == STREAM) || (r_state == DRAIN) || (r_state == LATCH);
    assign underrun   = w_underrun;

`ifdef LED_FRAME_STATS_EN
    logic [31:0] r_frames_src0;
    logic [31:0] r_frames_src1;
    logic [31:0] r_underruns;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_frames_src0 <= '0;
            r_frames_src1 <= '0;
            r_underruns   <= '0;
        end else begin
            if (w_grant && w_sel == SRC_HOST) begin
                r_frames_src0 <= r_frames_src0 + 32'd1;
            end
            if (w_grant && w_sel == SRC_FALLBACK) begin
                r_frames_src1 <= r_frames_src1 + 32'd1;
            end
            if (w_underrun) begin
                r_underruns <= r_underruns + 32'd1;
            end
        end
    end

    assign frames_src0 = r_frames_src0;
    assign frames_src1 = r_frames_src1;
    assign underruns   = r_underruns;
`endif

endmodule

// File: tb/tb_led_frame_scheduler.sv
// Randomized bench: two schedulers (fallback enabled / disabled) checked every cycle
// against a frame-level reference model; also covers reset values and an async reset mid-frame.
module tb_led_frame_scheduler;

    localparam int AW   = 12;
    localparam int DW   = 16;
    localparam int FW   = 8;
    localparam int FP   = 100;
    localparam int LT   = 10;
    localparam int NCYC = 6000;

    localparam int PH_IDLE   = 0;
    localparam int PH_ARB    = 1;
    localparam int PH_STREAM = 2;
    localparam int PH_DRAIN  = 3;
    localparam int PH_LATCH  = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic [AW:0]   src0_count;
    logic [AW:0]   src1_count;
    logic [DW-1:0] src0_data;
    logic [DW-1:0] src1_data;
    logic          src0_valid;
    logic          src1_valid;

    logic          drv_read      [2];
    logic          string_active [2];
    logic          src0_read     [2];
    logic          src1_read     [2];
    logic [AW:0]   drv_count     [2];
    logic [DW-1:0] drv_data      [2];
    logic          drv_valid     [2];
    logic          frame_src     [2];
    logic          frame_busy    [2];
    logic          underrun      [2];
`ifdef LED_FRAME_STATS_EN
    logic [31:0]   st_f0 [2];
    logic [31:0]   st_f1 [2];
    logic [31:0]   st_un [2];
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state, one entry per instance (0: fallback on, 1: fallback off).
    int m_edges  [2];
    bit m_pend   [2];
    int m_ph     [2];
    bit m_src    [2];
    int m_taken  [2];
    bit m_seen   [2];
    int m_quiet  [2];
    bit m_gap_ok [2];
    int m_hold   [2];
    int m_f0     [2];
    int m_f1     [2];
    int m_un     [2];
    int exp_un_pulses [2];
    int obs_un_pulses [2];

    always #25 clk = ~clk;

    led_frame_scheduler #(
        .FIFO_ADDR_WIDTH(AW), .FIFO_DATA_WIDTH(DW), .FRAME_WORDS(FW),
        .FRAME_PERIOD(FP), .LATCH_TICKS(LT), .FALLBACK_EN_P(1)
    ) u_dut_fb (
        .clk(clk), .reset(reset), .enable(enable),
        .src0_count(src0_count), .src0_data(src0_data), .src0_valid(src0_valid), .src0_read(src0_read[0]),
        .src1_count(src1_count), .src1_data(src1_data), .src1_valid(src1_valid), .src1_read(src1_read[0]),
        .drv_count(drv_count[0]), .drv_data(drv_data[0]), .drv_valid(drv_valid[0]), .drv_read(drv_read[0]),
        .string_active(string_active[0]), .frame_src(frame_src[0]), .frame_busy(frame_busy[0]),
        .underrun(underrun[0])
`ifdef LED_FRAME_STATS_EN
        , .frames_src0(st_f0[0]), .frames_src1(st_f1[0]), .underruns(st_un[0])
`endif
    );

    led_frame_scheduler #(
        .FIFO_ADDR_WIDTH(AW), .FIFO_DATA_WIDTH(DW), .FRAME_WORDS(FW),
        .FRAME_PERIOD(FP), .LATCH_TICKS(LT), .FALLBACK_EN_P(0)
    ) u_dut_nf (
        .clk(clk), .reset(reset), .enable(enable),
        .src0_count(src0_count), .src0_data(src0_data), .src0_valid(src0_valid), .src0_read(src0_read[1]),
        .src1_count(src1_count), .src1_data(src1_data), .src1_valid(src1_valid), .src1_read(src1_read[1]),
        .drv_count(drv_count[1]), .drv_data(drv_data[1]), .drv_valid(drv_valid[1]), .drv_read(drv_read[1]),
        .string_active(string_active[1]), .frame_src(frame_src[1]), .frame_busy(frame_busy[1]),
        .underrun(underrun[1])
`ifdef LED_FRAME_STATS_EN
        , .frames_src0(st_f0[1]), .frames_src1(st_f1[1]), .underruns(st_un[1])
`endif
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    // Source chosen by a frame-start opportunity right now, or -1 if none qualifies.
    function automatic int pick(input int u);
        if (src0_count >= FW) return 0;
        if (u == 0 && src1_count >= FW) return 1;
        return -1;
    endfunction

    task automatic model_reset(input int u);
        m_edges[u]  = 0;
        m_pend[u]   = 1'b0;
        m_ph[u]     = PH_IDLE;
        m_src[u]    = 1'b0;
        m_taken[u]  = 0;
        m_seen[u]   = 1'b0;
        m_quiet[u]  = 0;
        m_gap_ok[u] = 1'b1;
        m_hold[u]   = 0;
        m_f0[u]     = 0;
        m_f1[u]     = 0;
        m_un[u]     = 0;
    endtask

    // One clock edge of the scheduling rules, using the inputs present at that edge.
    task automatic model_step(input int u);
        int s;
        bit tick;
        tick = ((m_edges[u] % FP) == FP - 1);
        m_edges[u]++;
        case (m_ph[u])
            PH_IDLE: if (m_pend[u] && enable && m_gap_ok[u]) m_ph[u] = PH_ARB;
            PH_ARB: begin
                s = pick(u);
                if (s >= 0) begin
                    m_src[u]    = (s == 1);
                    m_taken[u]  = 0;
                    m_seen[u]   = 1'b0;
                    m_gap_ok[u] = 1'b0;
                    if (s == 0) m_f0[u]++; else m_f1[u]++;
                    m_ph[u] = PH_STREAM;
                end else begin
                    m_un[u]++;
                    m_ph[u] = PH_IDLE;
                end
                m_pend[u] = 1'b0;
            end
            PH_STREAM: begin
                if (drv_read[u]) begin
                    m_taken[u]++;
                    if (m_taken[u] == FW) m_ph[u] = PH_DRAIN;
                end
            end
            PH_DRAIN: begin
                if (string_active[u]) m_seen[u] = 1'b1;
                else if (m_seen[u]) begin
                    m_quiet[u] = 0;
                    m_ph[u]    = PH_LATCH;
                end
            end
            PH_LATCH: begin
                m_quiet[u] = string_active[u] ? 0 : m_quiet[u] + 1;
                if (m_quiet[u] == LT) begin
                    m_gap_ok[u] = 1'b1;
                    m_ph[u]     = PH_IDLE;
                end
            end
            default: m_ph[u] = PH_IDLE;
        endcase
        if (tick) m_pend[u] = 1'b1;
    endtask

    // Driver emulation: reads while streaming, flush reads while draining, busy strings with glitches.
    task automatic drive_unit(input int u, input int prev_ph);
        drv_read[u]      = 1'b0;
        string_active[u] = 1'b0;
        case (m_ph[u])
            PH_STREAM: begin
                drv_read[u]      = ($urandom_range(0, 2) != 0);
                string_active[u] = 1'b1;
            end
            PH_DRAIN: begin
                if (prev_ph == PH_STREAM) m_hold[u] = $urandom_range(1, 6);
                drv_read[u]      = ($urandom_range(0, 5) == 0);
                string_active[u] = (m_hold[u] > 0);
                if (m_hold[u] > 0) m_hold[u]--;
            end
            PH_LATCH: string_active[u] = ($urandom_range(0, 19) == 0);
            default: ;
        endcase
    endtask

    task automatic check_unit(input int u);
        bit fwd;
        logic [AW:0] exp_cnt;
        bit exp_un;
        bit exp_busy;
        fwd      = (m_ph[u] == PH_STREAM) || (m_ph[u] == PH_DRAIN);
        exp_cnt  = (m_ph[u] == PH_STREAM) ? (m_src[u] ? src1_count : src0_count) : '0;
        exp_un   = (m_ph[u] == PH_ARB) && (pick(u) < 0);
        exp_busy = ((m_ph[u] == PH_ARB) && (pick(u) >= 0)) || (m_ph[u] == PH_STREAM)
                   || (m_ph[u] == PH_DRAIN) || (m_ph[u] == PH_LATCH);
        chk($sformatf("u%0d drv_count", u), 32'(drv_count[u]), 32'(exp_cnt));
        chk($sformatf("u%0d src0_read", u), 32'(src0_read[u]), 32'(fwd && drv_read[u] && !m_src[u]));
        chk($sformatf("u%0d src1_read", u), 32'(src1_read[u]), 32'(fwd && drv_read[u] && m_src[u]));
        chk($sformatf("u%0d underrun", u), 32'(underrun[u]), 32'(exp_un));
        chk($sformatf("u%0d frame_busy", u), 32'(frame_busy[u]), 32'(exp_busy));
        chk($sformatf("u%0d frame_src", u), 32'(frame_src[u]), 32'(m_src[u]));
        if (fwd) begin
            chk($sformatf("u%0d drv_valid", u), 32'(drv_valid[u]), 32'(m_src[u] ? src1_valid : src0_valid));
            chk($sformatf("u%0d drv_data", u), 32'(drv_data[u]), 32'(m_src[u] ? src1_data : src0_data));
        end
        if (exp_un) exp_un_pulses[u]++;
        if (underrun[u] === 1'b1) obs_un_pulses[u]++;
    endtask

    task automatic check_zero(input string tag, input int u);
        chk($sformatf("%s u%0d drv_count", tag, u), 32'(drv_count[u]), 32'd0);
        chk($sformatf("%s u%0d drv_data", tag, u), 32'(drv_data[u]), 32'd0);
        chk($sformatf("%s u%0d drv_valid", tag, u), 32'(drv_valid[u]), 32'd0);
        chk($sformatf("%s u%0d src0_read", tag, u), 32'(src0_read[u]), 32'd0);
        chk($sformatf("%s u%0d src1_read", tag, u), 32'(src1_read[u]), 32'd0);
        chk($sformatf("%s u%0d frame_src", tag, u), 32'(frame_src[u]), 32'd0);
        chk($sformatf("%s u%0d frame_busy", tag, u), 32'(frame_busy[u]), 32'd0);
        chk($sformatf("%s u%0d underrun", tag, u), 32'(underrun[u]), 32'd0);
    endtask

    task automatic randomize_sources();
        int ctab [6];
        ctab = '{0, 3, 7, 8, 9, 20};
        if ($urandom_range(0, 39) == 0) src0_count = (AW + 1)'(ctab[$urandom_range(0, 5)]);
        if ($urandom_range(0, 39) == 0) src1_count = (AW + 1)'(ctab[$urandom_range(0, 5)]);
        src0_data  = DW'($urandom);
        src1_data  = DW'($urandom);
        src0_valid = $urandom_range(0, 1) == 1;
        src1_valid = $urandom_range(0, 1) == 1;
        enable     = ($urandom_range(0, 7) != 0);
    endtask

    initial begin
        int prev_ph;
        bit did_reset;
        did_reset  = 1'b0;
        reset      = 1'b1;
        enable     = 1'b1;
        src0_count = (AW + 1)'(FW);
        src1_count = '0;
        src0_data  = '0;
        src1_data  = '0;
        src0_valid = 1'b0;
        src1_valid = 1'b0;
        for (int u = 0; u < 2; u++) begin
            drv_read[u]      = 1'b1;
            string_active[u] = 1'b0;
            model_reset(u);
            exp_un_pulses[u] = 0;
            obs_un_pulses[u] = 0;
        end
        repeat (2) @(negedge clk);
        for (int u = 0; u < 2; u++) check_zero("reset", u);
        for (int u = 0; u < 2; u++) drv_read[u] = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;

        for (int c = 0; c < NCYC; c++) begin
            @(negedge clk);
            for (int u = 0; u < 2; u++) check_unit(u);
            if (!did_reset && m_ph[0] == PH_STREAM && m_taken[0] == 4) begin
                reset = 1'b1;
                #1;
                for (int u = 0; u < 2; u++) check_zero("async_rst", u);
                did_reset = 1'b1;
                for (int u = 0; u < 2; u++) begin
                    model_reset(u);
                    drv_read[u]      = 1'b0;
                    string_active[u] = 1'b0;
                end
                @(posedge clk);
                #1 reset = 1'b0;
                continue;
            end
            @(posedge clk);
            for (int u = 0; u < 2; u++) begin
                prev_ph = m_ph[u];
                model_step(u);
                m_hold[u] = (m_ph[u] == PH_DRAIN) ? m_hold[u] : 0;
                #0;
                drive_unit(u, prev_ph);
            end
            #1;
            randomize_sources();
        end

        @(negedge clk);
        chk("async reset exercised", 32'(did_reset), 32'd1);
        for (int u = 0; u < 2; u++) begin
            chk($sformatf("u%0d underrun pulse total", u), 32'(obs_un_pulses[u]), 32'(exp_un_pulses[u]));
`ifdef LED_FRAME_STATS_EN
            chk($sformatf("u%0d frames_src0", u), st_f0[u], 32'(m_f0[u]));
            chk($sformatf("u%0d frames_src1", u), st_f1[u], 32'(m_f1[u]));
            chk($sformatf("u%0d underruns", u), st_un[u], 32'(m_un[u]));
`endif
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
